// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm note datapath.
// Holds state/level encodings, lane count and default spawn thresholds.
package rhythm_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LVL_EASY   = 2'd0,
        LVL_NORM   = 2'd1,
        LVL_HARD   = 2'd2,
        LVL_EXPERT = 2'd3
    } level_t;

    localparam logic [3:0] THR_EASY_DEF   = 4'd4;
    localparam logic [3:0] THR_NORM_DEF   = 4'd8;
    localparam logic [3:0] THR_HARD_DEF   = 4'd12;
    localparam logic [3:0] THR_EXPERT_DEF = 4'd15;

    function automatic logic [NUM_LANES-1:0] lane_onehot(
        input logic [1:0] idx
    );
        lane_onehot = NUM_LANES'(1) << idx;
    endfunction

    function automatic logic cap_for_level(input level_t lvl);
        cap_for_level = (lvl == LVL_EASY) || (lvl == LVL_NORM);
    endfunction

endpackage

// File: rtl/note_lane_cap.sv
// Lane cap: optionally keeps only the two lowest set bits of a pattern.
// Purely combinational so chart/replay logic can share it.
module note_lane_cap
    import rhythm_pkg::*;
(
    input  logic [NUM_LANES-1:0] pattern,
    input  logic                 cap_en,
    output logic [NUM_LANES-1:0] lanes
);

    logic [NUM_LANES-1:0] low1;
    logic [NUM_LANES-1:0] rest;
    logic [NUM_LANES-1:0] low2;

    // x & -x isolates the lowest set bit
    always_comb begin
        low1 = pattern & (~pattern + NUM_LANES'(1));
        rest = pattern & ~low1;
        low2 = rest & (~rest + NUM_LANES'(1));
        if (cap_en) begin
            lanes = low1 | low2;
        end else begin
            lanes = pattern;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Beat-driven note spawner: picks lanes from the LFSR word on each beat
// and offers them downstream through a one-entry valid/ready holding register.
module note_scheduler
    import rhythm_pkg::*;
#(
    parameter int         SONG_BEATS = 256,
    parameter int         BEAT_CW    = 9,
    parameter logic [3:0] THR_EASY   = THR_EASY_DEF,
    parameter logic [3:0] THR_NORM   = THR_NORM_DEF,
    parameter logic [3:0] THR_HARD   = THR_HARD_DEF,
    parameter logic [3:0] THR_EXPERT = THR_EXPERT_DEF
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Stop,
    input  logic                 i_Beat,
    input  logic [1:0]           i_Level,
    input  logic [7:0]           i_Rand,
    input  logic                 i_Ready,
    output logic                 o_Valid,
    output logic [3:0]           o_Lanes,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [BEAT_CW-1:0]   o_BeatCnt,
    output logic [7:0]           o_Drop
);

    state_t state_q;
    state_t state_d;
    level_t level_q;

    logic       start_go;
    logic       beat_go;
    logic       last_beat;
    logic       xfer;
    logic       spawn;
    logic [3:0] thr;
    logic [3:0] raw_pat;
    logic [3:0] note_lanes;

    // Start is only honoured from IDLE/DONE and never alongside a stop
    assign start_go  = i_Start && !i_Stop && (state_q != ST_RUN);
    assign beat_go   = i_Beat && !i_Stop && (state_q == ST_RUN);
    assign last_beat = (o_BeatCnt == BEAT_CW'(SONG_BEATS - 1));
    assign xfer      = o_Valid && i_Ready;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_Stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (i_Start) state_d = ST_RUN;
                ST_RUN:  if (i_Beat && last_beat) state_d = ST_DONE;
                ST_DONE: if (i_Start) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_Busy = (state_q == ST_RUN);
        o_Done = (state_q == ST_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            level_q <= LVL_EASY;
        end else if (start_go) begin
            level_q <= level_t'(i_Level);
        end
    end

    always_comb begin
        thr = THR_EASY;
        unique case (level_q)
            LVL_EASY:   thr = THR_EASY;
            LVL_NORM:   thr = THR_NORM;
            LVL_HARD:   thr = THR_HARD;
            LVL_EXPERT: thr = THR_EXPERT;
            default:    thr = THR_EASY;
        endcase
    end

    // A zero pattern would be an empty note, so fall back to a rotating lane
    always_comb begin
        if (i_Rand[7:4] == 4'd0) begin
            raw_pat = lane_onehot(o_BeatCnt[1:0]);
        end else begin
            raw_pat = i_Rand[7:4];
        end
    end

    note_lane_cap u_cap (
        .pattern (raw_pat),
        .cap_en  (cap_for_level(level_q)),
        .lanes   (note_lanes)
    );

    assign spawn = beat_go && (i_Rand[3:0] < thr);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_BeatCnt <= '0;
        end else if (start_go) begin
            o_BeatCnt <= '0;
        end else if (beat_go) begin
            o_BeatCnt <= o_BeatCnt + BEAT_CW'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Valid <= 1'b0;
            o_Lanes <= '0;
        end else if (i_Stop || start_go) begin
            o_Valid <= 1'b0;
            o_Lanes <= '0;
        end else if (spawn && (!o_Valid || xfer)) begin
            o_Valid <= 1'b1;
            o_Lanes <= note_lanes;
        end else if (xfer) begin
            o_Valid <= 1'b0;
        end
    end

    // Held note wins over a new spawn; the loser is counted
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Drop <= '0;
        end else if (start_go) begin
            o_Drop <= '0;
        end else if (spawn && o_Valid && !xfer && (o_Drop != 8'hFF)) begin
            o_Drop <= o_Drop + 8'd1;
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a per-cycle reference model.
// Short song length keeps the end-of-song path reachable.
module tb_note_scheduler;

    localparam int SB = 4;
    localparam int CW = 9;

    logic          i_Clk;
    logic          i_Rst;
    logic          i_Start;
    logic          i_Stop;
    logic          i_Beat;
    logic [1:0]    i_Level;
    logic [7:0]    i_Rand;
    logic          i_Ready;
    logic          o_Valid;
    logic [3:0]    o_Lanes;
    logic          o_Busy;
    logic          o_Done;
    logic [CW-1:0] o_BeatCnt;
    logic [7:0]    o_Drop;

    int n_checks = 0;
    int n_fail   = 0;

    note_scheduler #(.SONG_BEATS(SB), .BEAT_CW(CW)) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Start   (i_Start),
        .i_Stop    (i_Stop),
        .i_Beat    (i_Beat),
        .i_Level   (i_Level),
        .i_Rand    (i_Rand),
        .i_Ready   (i_Ready),
        .o_Valid   (o_Valid),
        .o_Lanes   (o_Lanes),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done),
        .o_BeatCnt (o_BeatCnt),
        .o_Drop    (o_Drop)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: 0=idle 1=run 2=done
    int m_st, m_cnt, m_drop, m_lvl, m_valid, m_lanes;
    int thr_tab[4] = '{4, 8, 12, 15};

    function automatic int pick_lanes(int r, int cnt, int lvl);
        int pat, kept, res;
        pat = (r >> 4) & 15;
        if (pat == 0) pat = 1 << (cnt % 4);
        if (lvl >= 2) return pat;
        kept = 0;
        res  = 0;
        for (int b = 0; b < 4; b++) begin
            if (((pat >> b) & 1) == 1 && kept < 2) begin
                res  = res | (1 << b);
                kept = kept + 1;
            end
        end
        return res;
    endfunction

    always @(posedge i_Clk or negedge i_Rst) begin
        int  nl;
        bit  xf, sp;
        if (!i_Rst) begin
            m_st = 0; m_cnt = 0; m_drop = 0; m_lvl = 0;
            m_valid = 0; m_lanes = 0;
        end else if (i_Stop) begin
            m_st = 0; m_valid = 0; m_lanes = 0;
        end else if (i_Start && m_st != 1) begin
            m_st = 1; m_cnt = 0; m_drop = 0; m_lvl = int'(i_Level);
            m_valid = 0; m_lanes = 0;
        end else begin
            xf = (m_valid == 1) && i_Ready;
            sp = (m_st == 1) && i_Beat && (int'(i_Rand[3:0]) < thr_tab[m_lvl]);
            nl = pick_lanes(int'(i_Rand), m_cnt, m_lvl);
            if (m_st == 1 && i_Beat) begin
                if (m_cnt == SB - 1) m_st = 2;
                m_cnt = m_cnt + 1;
            end
            if (sp && m_valid == 1 && !xf) begin
                if (m_drop < 255) m_drop = m_drop + 1;
            end else if (sp) begin
                m_valid = 1;
                m_lanes = nl;
            end else if (xf) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge i_Clk) begin
        check("valid", 32'(o_Valid), 32'(m_valid));
        check("lanes", 32'(o_Lanes), 32'(m_lanes));
        check("busy", 32'(o_Busy), 32'(m_st == 1));
        check("done", 32'(o_Done), 32'(m_st == 2));
        check("beatcnt", 32'(o_BeatCnt), 32'(m_cnt));
        check("drop", 32'(o_Drop), 32'(m_drop));
    end

    task automatic beat(input logic [7:0] r);
        @(negedge i_Clk);
        i_Beat = 1'b1;
        i_Rand = r;
        @(negedge i_Clk);
        i_Beat = 1'b0;
    endtask

    task automatic start(input logic [1:0] lvl);
        @(negedge i_Clk);
        i_Start = 1'b1;
        i_Level = lvl;
        @(negedge i_Clk);
        i_Start = 1'b0;
    endtask

    task automatic stop();
        @(negedge i_Clk);
        i_Stop = 1'b1;
        @(negedge i_Clk);
        i_Stop = 1'b0;
    endtask

    initial begin
        i_Rst = 1'b0; i_Start = 1'b0; i_Stop = 1'b0; i_Beat = 1'b0;
        i_Level = 2'd0; i_Rand = 8'h00; i_Ready = 1'b1;
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b1;
        check("rst_valid", 32'(o_Valid), 32'h0);
        check("rst_busy", 32'(o_Busy), 32'h0);
        for (int i = 0; i < 3; i++) beat(8'($urandom));
        check("idle_beats_cnt", 32'(o_BeatCnt), 32'h0);
        check("idle_beats_valid", 32'(o_Valid), 32'h0);

        start(2'd3);
        check("run_busy", 32'(o_Busy), 32'h1);
        beat(8'hA7);
        check("l3_valid", 32'(o_Valid), 32'h1);
        check("l3_lanes", 32'(o_Lanes), 32'hA);
        @(negedge i_Clk);
        check("l3_xfer", 32'(o_Valid), 32'h0);
        check("l3_drop", 32'(o_Drop), 32'h0);

        stop();
        start(2'd0);
        beat(8'hF5);
        check("l0_nospawn", 32'(o_Valid), 32'h0);
        beat(8'hF3);
        check("l0_cap_valid", 32'(o_Valid), 32'h1);
        check("l0_cap_lanes", 32'(o_Lanes), 32'h3);

        stop();
        start(2'd1);
        beat(8'h1F);
        beat(8'h1F);
        check("l1_cnt2", 32'(o_BeatCnt), 32'h2);
        beat(8'h02);
        check("l1_onehot", 32'(o_Lanes), 32'h4);

        stop();
        start(2'd3);
        @(negedge i_Clk);
        i_Ready = 1'b0;
        beat(8'h31);
        beat(8'h52);
        beat(8'h93);
        check("bp_lanes", 32'(o_Lanes), 32'h3);
        check("bp_drop", 32'(o_Drop), 32'h2);
        i_Ready = 1'b1;
        beat(8'hC4);
        check("xs_valid", 32'(o_Valid), 32'h1);
        check("xs_lanes", 32'(o_Lanes), 32'hC);
        check("xs_drop", 32'(o_Drop), 32'h2);
        check("song_done", 32'(o_Done), 32'h1);
        check("song_cnt", 32'(o_BeatCnt), 32'h4);
        @(negedge i_Clk);
        check("done_xfer", 32'(o_Valid), 32'h0);
        beat(8'h01);
        check("done_ign_cnt", 32'(o_BeatCnt), 32'h4);
        check("done_ign_valid", 32'(o_Valid), 32'h0);

        @(negedge i_Clk);
        i_Start = 1'b1;
        i_Stop  = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        i_Stop  = 1'b0;
        check("ss_busy", 32'(o_Busy), 32'h0);
        check("ss_done", 32'(o_Done), 32'h0);
        check("ss_cnt_hold", 32'(o_BeatCnt), 32'h4);
        check("ss_drop_hold", 32'(o_Drop), 32'h2);

        start(2'd2);
        check("restart_drop", 32'(o_Drop), 32'h0);
        check("restart_cnt", 32'(o_BeatCnt), 32'h0);
        i_Ready = 1'b0;
        beat(8'hA7);
        check("pre_rst_valid", 32'(o_Valid), 32'h1);
        #2 i_Rst = 1'b0;
        #1;
        check("arst_valid", 32'(o_Valid), 32'h0);
        check("arst_lanes", 32'(o_Lanes), 32'h0);
        check("arst_busy", 32'(o_Busy), 32'h0);
        check("arst_cnt", 32'(o_BeatCnt), 32'h0);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        i_Ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'($urandom));
        check("post_rst_cnt", 32'(o_BeatCnt), 32'h0);
        check("post_rst_valid", 32'(o_Valid), 32'h0);
        repeat (2) @(negedge i_Clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
